// File: rtl/cell_filter_if.sv
// cell_filter_if: pixel-slot bundle between the 3x3 window generator and
// cell_filter.
//   iEn      pixel-slot enable
//   iSof     start of frame, qualified by iEn
//   iA..iI   3x3 window taps {R[2:0],G[2:0],B[2:0]}; A top-left, E centre
//   iBypass  per-pixel filter bypass (only with CELL_FILTER_BYPASS_EN)
//   oRGB     filtered pixel
//   oValid   high once the pipeline holds a real result
// Modports: master = window generator side, slave = cell_filter.
interface cell_filter_if;
  logic       iEn;
  logic       iSof;
  logic [8:0] iA, iB, iC, iD, iE, iF, iG, iH, iI;
`ifdef CELL_FILTER_BYPASS_EN
  logic       iBypass;
`endif
  logic [8:0] oRGB;
  logic       oValid;

  modport master (
`ifdef CELL_FILTER_BYPASS_EN
    output iBypass,
`endif
    output iEn, iSof, iA, iB, iC, iD, iE, iF, iG, iH, iI,
    input  oRGB, oValid
  );

  modport slave (
`ifdef CELL_FILTER_BYPASS_EN
    input  iBypass,
`endif
    input  iEn, iSof, iA, iB, iC, iD, iE, iF, iG, iH, iI,
    output oRGB, oValid
  );
endinterface

// File: rtl/cell_filter.sv
// cell_filter: 3x3 binomial blur (1 2 1 / 2 4 2 / 1 2 1, rounded >> 4) on
// each 3-bit channel of a 9-bit RGB pixel. Three pipeline stages, all
// advancing only on iEn. Pixels in the first two columns or rows of a frame
// pass the centre tap E through, since their windows hold stale line data.
// Ports:
//   iClk27  pixel clock
//   iRst    asynchronous, active-high reset
//   bus     cell_filter_if.slave (iEn, iSof, iA..iI, [iBypass], oRGB, oValid)
// Optional build macro: CELL_FILTER_BYPASS_EN adds iBypass, which forces
// the centre tap through for that pixel with unchanged latency.
module cell_filter #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
) (
  input  logic         iClk27,
  input  logic         iRst,
  cell_filter_if.slave bus
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  function automatic logic [4:0] row_sum(input logic [2:0] a, b, c);
    return 5'(a) + 5'({b, 1'b0}) + 5'(c);
  endfunction

  function automatic logic [6:0] col_sum(input logic [4:0] r0, r1, r2);
    return 7'(r0) + 7'({r1, 1'b0}) + 7'(r2);
  endfunction

  // Max total is 112, so (total + 8) fits 7 bits and the top 3 bits are
  // the rounded result without saturation.
  function automatic logic [2:0] round_div16(input logic [6:0] t);
    logic [6:0] s;
    s = t + 7'd8;
    return s[6:4];
  endfunction

  logic [COL_W-1:0] col_q, col_d, cur_col;
  logic [ROW_W-1:0] row_q, row_d, cur_row;
  logic [1:0]       fill_q, fill_d;
  logic             border, bypass;

  // S1: [channel][window row] row sums
  logic [2:0][2:0][4:0] s1_rows_q, s1_rows_d;
  logic [8:0]           s1_e_q, s1_e_d;
  logic                 s1_pass_q, s1_pass_d;
  // S2: per-channel weighted totals
  logic [2:0][6:0]      s2_total_q, s2_total_d;
  logic [8:0]           s2_e_q, s2_e_d;
  logic                 s2_pass_q, s2_pass_d;
  // S3
  logic [8:0]           rgb_q, rgb_d;

  // NOTE: every combinational output gets its hold value first so a path
  // that skips an assignment cannot infer a latch.
  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    fill_d     = fill_q;
    s1_rows_d  = s1_rows_q;
    s1_e_d     = s1_e_q;
    s1_pass_d  = s1_pass_q;
    s2_total_d = s2_total_q;
    s2_e_d     = s2_e_q;
    s2_pass_d  = s2_pass_q;
    rgb_d      = rgb_q;

    // A start-of-frame sample is (0,0) regardless of where the counters are.
    cur_col = bus.iSof ? '0 : col_q;
    cur_row = bus.iSof ? '0 : row_q;
    border  = (cur_col < COL_W'(2)) || (cur_row < ROW_W'(2));
`ifdef CELL_FILTER_BYPASS_EN
    bypass  = bus.iBypass;
`else
    bypass  = 1'b0;
`endif

    if (bus.iEn) begin
      if (bus.iSof) begin
        col_d  = COL_W'(1);
        row_d  = '0;
        fill_d = 2'd1;
      end else begin
        fill_d = (fill_q == 2'd3) ? 2'd3 : fill_q + 2'd1;
        if (col_q == COL_LAST) begin
          col_d = '0;
          row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_d = col_q + 1'b1;
        end
      end

      for (int ch = 0; ch < 3; ch++) begin
        s1_rows_d[ch][0] = row_sum(bus.iA[3*ch +: 3], bus.iB[3*ch +: 3], bus.iC[3*ch +: 3]);
        s1_rows_d[ch][1] = row_sum(bus.iD[3*ch +: 3], bus.iE[3*ch +: 3], bus.iF[3*ch +: 3]);
        s1_rows_d[ch][2] = row_sum(bus.iG[3*ch +: 3], bus.iH[3*ch +: 3], bus.iI[3*ch +: 3]);
        s2_total_d[ch]   = col_sum(s1_rows_q[ch][0], s1_rows_q[ch][1], s1_rows_q[ch][2]);
        rgb_d[3*ch +: 3] = round_div16(s2_total_q[ch]);
      end

      // Border and bypass both mean "emit E", so one carried flag serves both.
      s1_e_d    = bus.iE;
      s1_pass_d = border | bypass;
      s2_e_d    = s1_e_q;
      s2_pass_d = s1_pass_q;
      if (s2_pass_q) rgb_d = s2_e_q;
    end
  end

  // NOTE: state updates use non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // The pipeline is a handful of flops (no RAM), so all of it is reset.
  always_ff @(posedge iClk27 or posedge iRst) begin
    if (iRst) begin
      col_q      <= '0;
      row_q      <= '0;
      fill_q     <= '0;
      s1_rows_q  <= '0;
      s1_e_q     <= '0;
      s1_pass_q  <= 1'b0;
      s2_total_q <= '0;
      s2_e_q     <= '0;
      s2_pass_q  <= 1'b0;
      rgb_q      <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      fill_q     <= fill_d;
      s1_rows_q  <= s1_rows_d;
      s1_e_q     <= s1_e_d;
      s1_pass_q  <= s1_pass_d;
      s2_total_q <= s2_total_d;
      s2_e_q     <= s2_e_d;
      s2_pass_q  <= s2_pass_d;
      rgb_q      <= rgb_d;
    end
  end

  assign bus.oRGB   = rgb_q;
  assign bus.oValid = (fill_q == 2'd3);

endmodule

// File: tb/tb_cell_filter.sv
module tb_cell_filter;

  localparam int WIDTH  = 640;
  localparam int HEIGHT = 480;
`ifdef CELL_FILTER_BYPASS_EN
  localparam bit BYPASS_ON = 1'b1;
`else
  localparam bit BYPASS_ON = 1'b0;
`endif

  typedef logic [8:0] win_t [9];

  logic clk = 1'b0;
  logic rst = 1'b1;

  cell_filter_if bus ();

  cell_filter #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
    .iClk27 (clk),
    .iRst   (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;

  // Reference model: coordinates of the next sample, enables since the last
  // start of frame / reset, and the list of results in sample order.
  int         m_col, m_row, m_since;
  logic [8:0] hist[$];
  logic [8:0] exp_rgb;
  logic       exp_valid;

  function automatic logic [8:0] ref_pixel(input win_t w, input bit pass);
    int         wt[9];
    int         sum;
    logic [8:0] res;
    wt = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
    if (pass) return w[4];
    res = '0;
    for (int ch = 0; ch < 3; ch++) begin
      sum = 0;
      for (int k = 0; k < 9; k++) sum += wt[k] * int'((w[k] >> (3 * ch)) & 9'h7);
      res[3*ch +: 3] = 3'((sum + 8) / 16);
    end
    return res;
  endfunction

  task automatic model_reset();
    hist.delete();
    m_col = 0; m_row = 0; m_since = 0;
    exp_rgb = '0; exp_valid = 1'b0;
  endtask

  task automatic model_sample(input bit sof, input win_t w, input bit byp);
    int cc, cr, n;
    cc = sof ? 0 : m_col;
    cr = sof ? 0 : m_row;
    hist.push_back(ref_pixel(w, (cc < 2) || (cr < 2) || byp));
    m_since = sof ? 1 : m_since + 1;
    m_col = cc + 1;
    m_row = cr;
    if (m_col == WIDTH) begin
      m_col = 0;
      m_row = (cr + 1 == HEIGHT) ? 0 : cr + 1;
    end
    n = hist.size();
    exp_rgb   = (n >= 3) ? hist[n-3] : 9'h000;
    exp_valid = (m_since >= 3);
  endtask

  task automatic rand_win(output win_t w);
    for (int k = 0; k < 9; k++) w[k] = 9'($urandom);
  endtask

  task automatic const_win(output win_t w, input logic [8:0] others, input logic [8:0] centre);
    for (int k = 0; k < 9; k++) w[k] = others;
    w[4] = centre;
  endtask

  // Drive one pixel slot away from the edge, then update the model.
  task automatic step(input bit en, input bit sof, input win_t w, input bit byp);
    @(negedge clk);
    bus.iEn = en; bus.iSof = sof;
    bus.iA = w[0]; bus.iB = w[1]; bus.iC = w[2];
    bus.iD = w[3]; bus.iE = w[4]; bus.iF = w[5];
    bus.iG = w[6]; bus.iH = w[7]; bus.iI = w[8];
`ifdef CELL_FILTER_BYPASS_EN
    bus.iBypass = byp;
`endif
    @(posedge clk);
    #1;
    if (en) model_sample(sof, w, byp & BYPASS_ON);
  endtask

  task automatic run_to(input int r, input int c);
    win_t w;
    int   budget;
    budget = 0;
    while (!(m_row == r && m_col == c) && budget < 4000) begin
      rand_win(w);
      step(1'b1, 1'b0, w, ($urandom % 4) == 0);
      budget++;
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL run_to(%0d,%0d): oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 r, c, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
    end
    if (budget >= 4000) begin
      miscompares++;
      $display("FAIL run_to timeout: at (%0d,%0d), wanted (%0d,%0d)", m_row, m_col, r, c);
    end
  endtask

  task automatic test_reset();
    win_t w;
    rand_win(w);
    bus.iEn = 1'b1; bus.iSof = 1'b0;
    bus.iA = w[0]; bus.iB = w[1]; bus.iC = w[2]; bus.iD = w[3]; bus.iE = w[4];
    bus.iF = w[5]; bus.iG = w[6]; bus.iH = w[7]; bus.iI = w[8];
`ifdef CELL_FILTER_BYPASS_EN
    bus.iBypass = 1'b0;
`endif
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (bus.oRGB !== 9'h000) begin
      miscompares++;
      $display("FAIL reset oRGB: got %h, expected 000", bus.oRGB);
    end
    vectors++;
    if (bus.oValid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset oValid: got %b, expected 0", bus.oValid);
    end
    @(negedge clk);
    bus.iEn = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_full_white();
    win_t w;
    rand_win(w);
    step(1'b1, 1'b1, w, 1'b0);
    run_to(2, 0);
    const_win(w, 9'h1FF, 9'h1FF);
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 1'b0, w, 1'b0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL white[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
    end
    vectors++;
    if (bus.oRGB !== 9'h1FF || bus.oValid !== 1'b1) begin
      miscompares++;
      $display("FAIL white blur: oRGB=%h oValid=%b, expected 1FF/1", bus.oRGB, bus.oValid);
    end
  endtask

  task automatic test_impulse();
    win_t w;
    run_to(3, 5);
    const_win(w, 9'h000, 9'h1C0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, w, 1'b0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL impulse[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
      const_win(w, 9'h000, 9'h000);
    end
    vectors++;
    if (bus.oRGB !== 9'h080) begin
      miscompares++;
      $display("FAIL impulse result: got %h, expected 080", bus.oRGB);
    end
  endtask

  task automatic test_border();
    win_t w;
    run_to(4, 0);
    const_win(w, 9'h1FF, 9'h155);
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 1'b0, w, 1'b0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL border[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
      if (i == 2 || i == 3) begin
        vectors++;
        if (bus.oRGB !== 9'h155) begin
          miscompares++;
          $display("FAIL border col%0d passthrough: got %h, expected 155", i - 2, bus.oRGB);
        end
      end
    end
  endtask

  task automatic test_stall();
    win_t w;
    bit   pat[5];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 5; i++) begin
      rand_win(w);
      // iSof with iEn low must be ignored.
      step(pat[i], !pat[i], w, 1'b0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL stall_pat[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
    end
    for (int i = 0; i < 300; i++) begin
      rand_win(w);
      step(1'($urandom % 2), 1'b0, w, ($urandom % 4) == 0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL stall_rand[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
    end
  endtask

  task automatic test_reset_mid();
    win_t w;
    run_to((m_col <= 300) ? m_row : m_row + 1, 300);
    @(negedge clk);
    bus.iEn = 1'b1;
    rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
      miscompares++;
      $display("FAIL mid reset: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
               bus.oRGB, bus.oValid, exp_rgb, exp_valid);
    end
    @(negedge clk);
    bus.iEn = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      rand_win(w);
      step(1'b1, 1'b0, w, 1'b0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL post reset[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
      if (i == 2) begin
        vectors++;
        if (bus.oValid !== 1'b1) begin
          miscompares++;
          $display("FAIL post reset valid: got %b, expected 1", bus.oValid);
        end
      end
    end
  endtask

  task automatic test_sof_valid_drop();
    win_t w;
    for (int i = 0; i < 4; i++) begin
      rand_win(w);
      step(1'b1, i == 0, w, 1'b0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL sof[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
    end
  endtask

  task automatic test_bypass();
    win_t w;
    rand_win(w);
    step(1'b1, 1'b1, w, 1'b0);
    run_to(3, 5);
    const_win(w, 9'h000, 9'h1C0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, w, i == 0);
      vectors++;
      if (bus.oRGB !== exp_rgb || bus.oValid !== exp_valid) begin
        miscompares++;
        $display("FAIL bypass[%0d]: oRGB=%h oValid=%b, expected oRGB=%h oValid=%b",
                 i, bus.oRGB, bus.oValid, exp_rgb, exp_valid);
      end
      const_win(w, 9'h000, 9'h000);
    end
    vectors++;
    if (bus.oRGB !== 9'h1C0) begin
      miscompares++;
      $display("FAIL bypass result: got %h, expected 1C0", bus.oRGB);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.iEn = 1'b0; bus.iSof = 1'b0;
    bus.iA = '0; bus.iB = '0; bus.iC = '0; bus.iD = '0; bus.iE = '0;
    bus.iF = '0; bus.iG = '0; bus.iH = '0; bus.iI = '0;
`ifdef CELL_FILTER_BYPASS_EN
    bus.iBypass = 1'b0;
`endif
    test_reset();
    test_full_white();
    test_impulse();
    test_border();
    test_stall();
    test_reset_mid();
    test_sof_valid_drop();
    if (BYPASS_ON) test_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
